// File: rtl/noc_output_buffer.sv
// noc_output_buffer: per-output-port first-word-fall-through flit buffer that sits
// between one crossbar output lane and the outgoing link.
module noc_output_buffer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           FIFO_ENQ,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] FIFO_IN,
    output logic                           FIFO_FULL,
    output logic                           OUT_VALID,
    output logic [ADDR_WIDTH-1:0]          OUT_ADDR,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    input  logic                           OUT_READY,
    output logic [CNT_WIDTH-1:0]           COUNT,
    output logic                           OVERFLOW
);

    localparam int PTR_WIDTH  = $clog2(DEPTH);
    localparam int FLIT_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  enq_ok, deq_ok;
    logic [FLIT_WIDTH-1:0] head;

    // Status is decoded only from registered state, never from the inputs.
    assign FIFO_FULL = (count_q == CNT_WIDTH'(DEPTH));
    assign OUT_VALID = (count_q != '0);
    assign COUNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign head      = mem_q[rptr_q];
    assign OUT_ADDR  = head[FLIT_WIDTH-1 -: ADDR_WIDTH];
    assign OUT_DATA  = head[DATA_WIDTH-1:0];

    assign enq_ok = FIFO_ENQ & ~FIFO_FULL;
    assign deq_ok = OUT_VALID & OUT_READY;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (FIFO_ENQ & FIFO_FULL);
        if (enq_ok) wptr_d = wptr_q + PTR_WIDTH'(1);
        if (deq_ok) rptr_d = rptr_q + PTR_WIDTH'(1);
        if (enq_ok && !deq_ok) count_d = count_q + CNT_WIDTH'(1);
        if (deq_ok && !enq_ok) count_d = count_q - CNT_WIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only observable after it is written.
    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[wptr_q] <= FIFO_IN;
    end

endmodule
